// File: rtl/dmem_pkg.sv
// Shared definitions for the data_memory block responder.
// Holds the FSM state encoding, default parameters and the range check helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int unsigned ADDR_W_DEF     = 28;
    localparam int unsigned BLOCK_W_DEF    = 128;
    localparam int unsigned DEPTH_LOG2_DEF = 8;
    localparam int unsigned LATENCY_DEF    = 5;

    // True when any block address bit above the present depth is set.
    function automatic logic out_of_range(
        input logic [31:0] addr,
        input int unsigned depth_log2
    );
        return (addr >> depth_log2) != 32'd0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port block storage: synchronous write, registered read.
// Ports: clock, we/re enables, addr, wdata in; rdata out (no reset, BRAM-friendly).
module dmem_array #(
    parameter int unsigned BLOCK_W    = 128,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [BLOCK_W-1:0]    wdata,
    output logic [BLOCK_W-1:0]    rdata
);

    logic [BLOCK_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [BLOCK_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Block memory responder for data-cache refill and write-back.
// Ports: clock, reset, mem_read/mem_write/mem_address/mem_writedata in;
//        mem_readdata, mem_busywait, mem_error out.
module data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned BLOCK_W    = BLOCK_W_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned LATENCY    = LATENCY_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic [BLOCK_W-1:0] mem_writedata,
    output logic [BLOCK_W-1:0] mem_readdata,
    output logic               mem_busywait,
    output logic               mem_error
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic               err_q, err_d;
    // Masks the array output: set by reset or an out-of-range read,
    // cleared by a legal read, so the storage itself needs no reset.
    logic               zero_q, zero_d;

    logic               arr_we;
    logic               arr_re;
    logic [BLOCK_W-1:0] arr_rdata;
    logic               busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        zero_d  = zero_q;
        arr_we  = 1'b0;
        arr_re  = 1'b0;
        busy    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = mem_read | mem_write;
                if (busy) begin
                    op_wr_d = mem_write;
                    addr_d  = mem_address;
                    wdata_d = mem_writedata;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                    if (mem_read && mem_write) begin
                        err_d = 1'b1;
                    end
                    if (out_of_range(32'(mem_address), DEPTH_LOG2)) begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (out_of_range(32'(addr_q), DEPTH_LOG2)) begin
                        if (!op_wr_q) begin
                            zero_d = 1'b1;
                        end
                    end else if (op_wr_q) begin
                        arr_we = 1'b1;
                    end else begin
                        arr_re = 1'b1;
                        zero_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset abandons any transaction, including an uncommitted write.
        if (reset) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            err_d   = 1'b0;
            zero_d  = 1'b1;
            arr_we  = 1'b0;
            arr_re  = 1'b0;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        op_wr_q <= op_wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        err_q   <= err_d;
        zero_q  <= zero_d;
    end

    dmem_array #(
        .BLOCK_W    (BLOCK_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_q[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign mem_readdata = zero_q ? '0 : arr_rdata;
    assign mem_busywait = busy;
    assign mem_error    = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Drives a LATENCY=5 instance and a LATENCY=1 instance from one clock.
module tb_data_memory;

    localparam logic [127:0] P10 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] P25 = 128'h25252525_11112222_33334444_55556666;
    localparam logic [127:0] P05 = 128'h05050505_AAAABBBB_CCCCDDDD_EEEEFFFF;
    localparam logic [127:0] P07 = 128'h07070707_12345678_9ABCDEF0_0F0F0F0F;
    localparam logic [127:0] DB  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] W05 = 128'hCAFEF00D_00000005_00000055_00000555;
    localparam logic [127:0] N07 = 128'hBAD00BAD_BAD00BAD_BAD00BAD_BAD00BAD;
    localparam logic [127:0] D02 = 128'h22222222_00000002_20202020_02020202;
    localparam logic [127:0] Q0A = 128'h0A0A0A0A_B0B0B0B0_C0C0C0C0_D0D0D0D0;

    logic         clock = 1'b0;
    logic         reset;
    logic         mem_read, mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait, mem_error;

    logic         r1_read, r1_write;
    logic [27:0]  r1_address;
    logic [127:0] r1_writedata;
    logic [127:0] r1_readdata;
    logic         r1_busywait, r1_error;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int n1;

    always #5 clock = ~clock;

    data_memory dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .mem_error     (mem_error)
    );

    data_memory #(.LATENCY(1)) u1 (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (r1_read),
        .mem_write     (r1_write),
        .mem_address   (r1_address),
        .mem_writedata (r1_writedata),
        .mem_readdata  (r1_readdata),
        .mem_busywait  (r1_busywait),
        .mem_error     (r1_error)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] d);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = a;
        mem_writedata = d;
    endtask

    task automatic drop();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Count edges until busywait is seen low (DONE cycle), bounded.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (mem_busywait && cnt < 40);
    endtask

    // One isolated transaction: busy seen at once, LATENCY+1 edges to DONE.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [27:0] a, input logic [127:0] d);
        int c;
        req(rd, wr, a, d);
        #1;
        chk({tag, "_busy_now"}, 128'(mem_busywait), 128'(1));
        wait_done(c);
        chk({tag, "_cycles"}, 128'(c), 128'(6));
        drop();
        step();
    endtask

    initial begin
        reset = 1'b1;
        drop();
        mem_address   = '0;
        mem_writedata = '0;
        r1_read       = 1'b0;
        r1_write      = 1'b0;
        r1_address    = '0;
        r1_writedata  = '0;
        step();
        mem_read = 1'b1;
        #1;
        chk("rst_busy_override", 128'(mem_busywait), 128'(0));
        step();
        chk("rst_readdata", mem_readdata, 128'(0));
        chk("rst_error", 128'(mem_error), 128'(0));
        drop();
        reset = 1'b0;
        step();

        txn("pre10", 1'b0, 1'b1, 28'h0000010, P10);
        txn("pre25", 1'b0, 1'b1, 28'h0000025, P25);
        txn("pre05", 1'b0, 1'b1, 28'h0000005, P05);
        txn("pre07", 1'b0, 1'b1, 28'h0000007, P07);
        chk("pre_readdata_zero", mem_readdata, 128'(0));

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_readdata", mem_readdata, 128'(0));

        txn("rd10", 1'b1, 1'b0, 28'h0000010, '0);
        chk("rd10_data", mem_readdata, P10);
        chk("rd10_err", 128'(mem_error), 128'(0));

        txn("wr03", 1'b0, 1'b1, 28'h0000003, DB);
        chk("wr03_keeps_rdata", mem_readdata, P10);
        txn("rd03", 1'b1, 1'b0, 28'h0000003, '0);
        chk("rd03_data", mem_readdata, DB);

        req(1'b0, 1'b1, 28'h0000005, W05);
        wait_done(n);
        chk("b2b_wr_cycles", 128'(n), 128'(6));
        req(1'b1, 1'b0, 28'h0000025, '0);
        wait_done(n1);
        chk("b2b_rd_cycles", 128'(n1), 128'(7));
        chk("b2b_rd_data", mem_readdata, P25);
        drop();
        step();
        chk("b2b_idle_busy", 128'(mem_busywait), 128'(0));
        txn("rd05", 1'b1, 1'b0, 28'h0000005, '0);
        chk("rd05_data", mem_readdata, W05);

        txn("oor", 1'b1, 1'b0, 28'h0100000, '0);
        chk("oor_data", mem_readdata, 128'(0));
        chk("oor_err", 128'(mem_error), 128'(1));
        txn("after_oor", 1'b1, 1'b0, 28'h0000010, '0);
        chk("after_oor_data", mem_readdata, P10);
        chk("after_oor_err_sticky", 128'(mem_error), 128'(1));

        req(1'b0, 1'b1, 28'h0000007, N07);
        step();
        step();
        step();
        chk("abort_busy_before", 128'(mem_busywait), 128'(1));
        reset = 1'b1;
        #1;
        chk("abort_busy_in_rst", 128'(mem_busywait), 128'(0));
        step();
        reset = 1'b0;
        drop();
        chk("abort_readdata", mem_readdata, 128'(0));
        chk("abort_err_clr", 128'(mem_error), 128'(0));
        step();
        txn("rd07", 1'b1, 1'b0, 28'h0000007, '0);
        chk("rd07_old", mem_readdata, P07);

        txn("both02", 1'b1, 1'b1, 28'h0000002, D02);
        chk("both02_err", 128'(mem_error), 128'(1));
        chk("both02_keeps_rdata", mem_readdata, P07);
        txn("rd02", 1'b1, 1'b0, 28'h0000002, '0);
        chk("rd02_data", mem_readdata, D02);

        r1_write     = 1'b1;
        r1_address   = 28'h000000A;
        r1_writedata = Q0A;
        n = 0;
        do begin
            step();
            n++;
        end while (r1_busywait && n < 40);
        chk("l1_wr_cycles", 128'(n), 128'(2));
        r1_write = 1'b0;
        step();
        r1_read = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (r1_busywait && n < 40);
        chk("l1_rd_cycles", 128'(n), 128'(2));
        chk("l1_rd_data", r1_readdata, Q0A);
        r1_read = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
